// File: rtl/lbdr_dr_route_unit.sv
// LBDR routing unit with deroute fallback and optional fork routing for one mesh input port.
// Ports: clk/rst; cfg_load + Rxy_in/Cx_in/Dr_in/cur_addr_in reload the config; empty/flit_id/dst_addr/grant
// come from the FIFO head and allocator; port_req/route_busy/derouted/err_* are registered outputs.
// The route is latched one cycle after a header and held until the tail is granted.
module lbdr_dr_route_unit #(
    parameter int unsigned COORD_W        = 2,
    parameter logic [2:0]  HEADER_ID      = 3'b001,
    parameter logic [2:0]  BODY_ID        = 3'b010,
    parameter logic [2:0]  TAIL_ID        = 3'b100,
    parameter bit          ENABLE_DEROUTE = 1'b1,
    parameter bit          ENABLE_FORK    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_load,
    input  logic [7:0]             Rxy_in,
    input  logic [3:0]             Cx_in,
    input  logic [7:0]             Dr_in,
    input  logic [2*COORD_W-1:0]   cur_addr_in,
    input  logic                   empty,
    input  logic [2:0]             flit_id,
    input  logic [2*COORD_W-1:0]   dst_addr,
    input  logic                   grant,
    output logic [4:0]             port_req,
    output logic                   route_busy,
    output logic                   derouted,
    output logic                   err_unroutable,
    output logic                   err_protocol
);

    localparam int unsigned AW = 2 * COORD_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ROUTE = 1'b1;

    logic [0:0]    state;
    logic [7:0]    rxy;
    logic [3:0]    cx;
    logic [7:0]    dr;
    logic [AW-1:0] cur_addr;
    // Set on route setup: the header that produced the route is still at the
    // FIFO head, so its own grant is legitimate. Only later headers are errors.
    logic          hdr_pending;

    logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
    logic n1, s1, e1, w1;
    logic m_n, m_e, m_w, m_s, m_l;
    logic [4:0] min_set;
    logic [4:0] sel;
    logic [1:0] prim_dir;
    logic [1:0] dr_port;
    logic       dr_ok;
    logic [4:0] next_req;
    logic       next_der;
    logic       route_ok;
    logic       is_hdr;
    logic       is_tail;

    assign x_cur = cur_addr[COORD_W-1:0];
    assign y_cur = cur_addr[AW-1:COORD_W];
    assign x_dst = dst_addr[COORD_W-1:0];
    assign y_dst = dst_addr[AW-1:COORD_W];

    assign n1 = (y_dst < y_cur);
    assign s1 = (y_cur < y_dst);
    assign e1 = (x_cur < x_dst);
    assign w1 = (x_dst < x_cur);

    // rxy bit order: {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}; cx: {Cs,Cw,Ce,Cn}
    assign m_n = cx[0] & ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy[0]) | (n1 & w1 & rxy[1]));
    assign m_e = cx[1] & ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy[2]) | (e1 & s1 & rxy[3]));
    assign m_w = cx[2] & ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy[4]) | (w1 & s1 & rxy[5]));
    assign m_s = cx[3] & ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy[6]) | (s1 & w1 & rxy[7]));
    assign m_l = ~n1 & ~e1 & ~w1 & ~s1;

    assign min_set = {m_n, m_e, m_w, m_s, m_l};

    assign is_hdr  = |(flit_id & HEADER_ID);
    assign is_tail = |(flit_id & TAIL_ID);

    always_comb begin
        sel = 5'b00000;
        if (ENABLE_FORK) begin
            sel = min_set;
        end else if (min_set[4]) begin
            sel = 5'b10000;
        end else if (min_set[3]) begin
            sel = 5'b01000;
        end else if (min_set[2]) begin
            sel = 5'b00100;
        end else if (min_set[1]) begin
            sel = 5'b00010;
        end else begin
            sel = {4'b0000, min_set[0]};
        end
    end

    // Primary direction index uses the port numbering 0=N,1=E,2=W,3=S,
    // which also matches the Cx bit positions.
    always_comb begin
        prim_dir = 2'd2;
        if (n1) begin
            prim_dir = 2'd0;
        end else if (s1) begin
            prim_dir = 2'd3;
        end else if (e1) begin
            prim_dir = 2'd1;
        end
    end

    always_comb begin
        dr_port = dr[1:0];
        case (prim_dir)
            2'd0:    dr_port = dr[1:0];
            2'd1:    dr_port = dr[3:2];
            2'd2:    dr_port = dr[5:4];
            default: dr_port = dr[7:6];
        endcase
    end

    assign dr_ok = ENABLE_DEROUTE && cx[dr_port];

    always_comb begin
        next_req = sel;
        next_der = 1'b0;
        route_ok = 1'b1;
        if (min_set == 5'b00000) begin
            if (dr_ok) begin
                next_req = 5'b10000 >> dr_port;
                next_der = 1'b1;
            end else begin
                next_req = 5'b00000;
                route_ok = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        err_unroutable <= 1'b0;
        err_protocol   <= 1'b0;
        if (rst) begin
            rxy         <= Rxy_in;
            cx          <= Cx_in;
            dr          <= Dr_in;
            cur_addr    <= cur_addr_in;
            state       <= ST_IDLE;
            port_req    <= 5'b00000;
            route_busy  <= 1'b0;
            derouted    <= 1'b0;
            hdr_pending <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (cfg_load) begin
                rxy      <= Rxy_in;
                cx       <= Cx_in;
                dr       <= Dr_in;
                cur_addr <= cur_addr_in;
            end
            if (!empty) begin
                if (is_hdr) begin
                    if (route_ok) begin
                        port_req    <= next_req;
                        derouted    <= next_der;
                        route_busy  <= 1'b1;
                        hdr_pending <= 1'b1;
                        state       <= ST_ROUTE;
                    end else begin
                        err_unroutable <= 1'b1;
                    end
                end else begin
                    err_protocol <= 1'b1;
                end
            end
        end else begin
            if (grant && !empty) begin
                if (is_tail) begin
                    port_req   <= 5'b00000;
                    derouted   <= 1'b0;
                    route_busy <= 1'b0;
                    state      <= ST_IDLE;
                end else if (is_hdr && !hdr_pending) begin
                    err_protocol <= 1'b1;
                end
                hdr_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lbdr_dr_route_unit.sv
module tb_lbdr_dr_route_unit;

    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;
    localparam logic [2:0] SGL  = 3'b101;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [7:0] Rxy_in;
    logic [3:0] Cx_in;
    logic [7:0] Dr_in;
    logic [3:0] cur_addr_in;
    logic       empty;
    logic [2:0] flit_id;
    logic [3:0] dst_addr;
    logic       grant;

    logic [4:0] port_req0, port_req1;
    logic       busy0, busy1, der0, der1, eu0, eu1, ep0, ep1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lbdr_dr_route_unit #(.COORD_W(2), .ENABLE_DEROUTE(1'b1), .ENABLE_FORK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .Rxy_in(Rxy_in), .Cx_in(Cx_in),
        .Dr_in(Dr_in), .cur_addr_in(cur_addr_in), .empty(empty), .flit_id(flit_id),
        .dst_addr(dst_addr), .grant(grant), .port_req(port_req0), .route_busy(busy0),
        .derouted(der0), .err_unroutable(eu0), .err_protocol(ep0)
    );

    lbdr_dr_route_unit #(.COORD_W(2), .ENABLE_DEROUTE(1'b1), .ENABLE_FORK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .Rxy_in(Rxy_in), .Cx_in(Cx_in),
        .Dr_in(Dr_in), .cur_addr_in(cur_addr_in), .empty(empty), .flit_id(flit_id),
        .dst_addr(dst_addr), .grant(grant), .port_req(port_req1), .route_busy(busy1),
        .derouted(der1), .err_unroutable(eu1), .err_protocol(ep1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Compact check of fork-off instance: {port_req, busy, derouted, err_u, err_p}
    task automatic chk0(input string tag, input logic [4:0] req, input logic b, input logic d,
                        input logic eu, input logic ep);
        chk({tag, "_req0"}, {3'b000, port_req0}, {3'b000, req});
        chk({tag, "_st0"}, {4'b0000, busy0, der0, eu0, ep0}, {4'b0000, b, d, eu, ep});
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0;
        Rxy_in = 8'h3C; Cx_in = 4'hF; Dr_in = 8'h00; cur_addr_in = 4'b0101;
        empty = 1'b1; flit_id = 3'b000; dst_addr = 4'b0000; grant = 1'b0;
        tick(); tick();
        chk0("reset", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_req1", {3'b000, port_req1}, 8'h00);
        rst = 1'b0;

        // Header NE-quadrant: Ren=1, Rne=0 -> East
        empty = 1'b0; flit_id = HDR; dst_addr = 4'b0011;
        tick();
        chk0("hdr_e", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        grant = 1'b1;                       // the routed header itself is granted
        tick();
        chk0("hdr_own_grant", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        flit_id = TAIL;
        tick();
        chk0("tail_exit", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Multi-flit packet: route held across header, body, body, tail
        grant = 1'b0; flit_id = HDR; dst_addr = 4'b0111;
        tick();
        chk0("pkt_c1", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        grant = 1'b1; dst_addr = 4'b0000;
        tick();
        chk0("pkt_c2", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        flit_id = BODY;
        cfg_load = 1'b1; Cx_in = 4'h0;     // must be ignored while routing
        tick();
        chk0("pkt_c3_cfg_ign", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        cfg_load = 1'b0;
        empty = 1'b1; flit_id = TAIL;       // grant while empty: ignored
        tick();
        chk0("pkt_empty_grant", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        empty = 1'b0; flit_id = BODY;
        tick();
        chk0("pkt_c4", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        flit_id = HDR;                      // stray header inside the packet
        tick();
        chk0("pkt_stray_hdr", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b1);
        flit_id = TAIL;
        tick();
        chk0("pkt_tail", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Config was not changed by the ignored load: East still reachable
        grant = 1'b0; flit_id = HDR; dst_addr = 4'b0011;
        tick();
        chk0("cfg_kept", 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);
        grant = 1'b1; flit_id = SGL;
        tick();
        chk0("cfg_kept_exit", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Deroute: North blocked, Dr[N]=E
        grant = 1'b0; empty = 1'b1;
        Cx_in = 4'b1110; Dr_in = 8'h01; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; empty = 1'b0; flit_id = HDR; dst_addr = 4'b0001;
        tick();
        chk0("deroute", 5'b01000, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("deroute_der1", {7'd0, der1}, 8'h01);
        grant = 1'b1; flit_id = SGL;
        tick();
        chk0("deroute_exit", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Deroute target also blocked -> unroutable
        grant = 1'b0; empty = 1'b1; Cx_in = 4'b1100; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; empty = 1'b0; flit_id = HDR; dst_addr = 4'b0001;
        tick();
        chk0("unroutable", 5'b00000, 1'b0, 1'b0, 1'b1, 1'b0);
        empty = 1'b1;
        tick();
        chk0("unroutable_pulse", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fork vs single: NW destination with all R bits set
        Rxy_in = 8'hFF; Cx_in = 4'hF; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0; empty = 1'b0; flit_id = HDR; dst_addr = 4'b0000;
        tick();
        chk0("nw_single", 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("nw_fork", {3'b000, port_req1}, 8'h14);
        grant = 1'b1; flit_id = TAIL;
        tick();
        chk("nw_fork_exit", {3'b000, port_req1}, 8'h00);

        // Local delivery, single-flit packet
        flit_id = SGL; dst_addr = 4'b0101;
        tick();
        chk0("local", 5'b00001, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("local_fork", {3'b000, port_req1}, 8'h01);
        tick();
        empty = 1'b1; grant = 1'b0;
        chk0("local_exit", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Body flit in IDLE
        empty = 1'b0; flit_id = BODY;
        tick();
        chk0("idle_body", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1);
        empty = 1'b1;
        tick();
        chk0("idle_body_pulse", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-packet: NE with Rne=Ren=1 -> N single, N+E fork
        empty = 1'b0; flit_id = HDR; dst_addr = 4'b0011;
        tick();
        chk0("pre_rst", 5'b10000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_fork", {3'b000, port_req1}, 8'h18);
        rst = 1'b1; flit_id = BODY;
        tick();
        chk0("mid_rst", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_fork", {3'b000, port_req1}, 8'h00);
        rst = 1'b0; empty = 1'b1;
        tick();
        chk0("post_rst", 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbdr_dr_route_unit.md
Name: lbdr_dr_route_unit

Overview:
Parametrised next-generation LBDR routing unit for one router input port of a 2D mesh NoC. It extends minimal LBDR with deroute fallback and optional fork (multi-port) routing. It has runtime-reloadable configuration and a packet-level FSM: the route is computed on the HEADER flit and held until the TAIL flit is granted. It sits between the input FIFO and the switch allocator.

Parameters:
COORD_W, 2, bits per X/Y coordinate; address width is 2*COORD_W, X in the low half, Y in the high half.
HEADER_ID, 3'b001, flit_id encoding for a header flit.
BODY_ID, 3'b010, flit_id encoding for a payload flit.
TAIL_ID, 3'b100, flit_id encoding for a tail flit; 3'b101 means a single-flit packet (header and tail).
ENABLE_DEROUTE, 1, 1 = use Dr bits when the minimal set is empty.
ENABLE_FORK, 0, 1 = assert all eligible minimal ports; 0 = one port, priority N>E>W>S.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_load  in  1  reload configuration registers (honoured only in IDLE)
Rxy_in  in  8  routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
Cx_in  in  4  connectivity {Cs,Cw,Ce,Cn}
Dr_in  in  8  deroute port index, 2 bits per primary direction [1:0]=N,[3:2]=E,[5:4]=W,[7:6]=S; index 0=N,1=E,2=W,3=S
cur_addr_in  in  2*COORD_W  this router's address
empty  in  1  input FIFO empty
flit_id  in  3  type of the flit at the FIFO head
dst_addr  in  2*COORD_W  destination of the head flit (meaningful on HEADER only)
grant  in  1  allocator consumed the head flit this cycle
port_req  out  5  requested output ports {N,E,W,S,L}, MSB=N
route_busy  out  1  FSM in ROUTE
derouted  out  1  current route came from Dr bits
err_unroutable  out  1  one-cycle pulse
err_protocol  out  1  one-cycle pulse

Behaviour:
- Config regs Rxy, Cx, Dr, cur_addr load from the *_in ports when rst=1, or when cfg_load=1 in IDLE. cfg_load in ROUTE is ignored, with no error.
- Reset: all outputs 0, FSM in IDLE.
- Comparators are unsigned COORD_W-bit: N1 = y_dst<y_cur, S1 = y_cur<y_dst, E1 = x_cur<x_dst, W1 = x_dst<x_cur.
- Minimal set M, each term ANDed with its C bit:
  - N = (N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw)
  - E = (E1&~N1&~S1)|(E1&N1&Ren)|(E1&S1&Res)
  - W = (W1&~N1&~S1)|(W1&N1&Rwn)|(W1&S1&Rws)
  - S = (S1&~E1&~W1)|(S1&E1&Rse)|(S1&W1&Rsw)
  - L = ~N1&~E1&~W1&~S1 (never masked)
- Selection:
  - ENABLE_FORK=0: lowest-priority-index single bit of M (N>E>W>S).
  - ENABLE_FORK=1: all of M.
- Deroute: if M is empty, L=0 and ENABLE_DEROUTE=1, take primary direction P (first true of N1,S1,E1,W1). Use port Dr[P] if its C bit is 1; set derouted=1. Otherwise the packet is unroutable.
- FSM states IDLE and ROUTE.
  - IDLE, !empty, flit_id has the header bit, routable: next cycle port_req=selection, route_busy=1, go to ROUTE. Latency is 1 cycle.
  - IDLE, header, unroutable: err_unroutable pulses, port_req stays 0, state stays IDLE. The upstream drops the flit.
  - IDLE, !empty, non-header flit: err_protocol pulses, state stays IDLE.
  - ROUTE: port_req and derouted are held constant regardless of dst_addr.
  - ROUTE exit: on grant & !empty & tail bit set, next cycle port_req=0, route_busy=0, derouted=0, go to IDLE. A single-flit packet (3'b101) exits on its first grant.
  - ROUTE, grant on a header flit without tail: err_protocol pulses, route is held.
  - grant while empty is ignored.
- empty=1 never clears a held route; only tail+grant or rst does.
- rst mid-packet: outputs 0 and state IDLE next cycle; the partial packet is abandoned.

Test Plan:
- COORD_W=2, Rxy=8'h3C, Cx=4'hF, cur=4'b0101, FORK=0; HEADER dst=4'b0011 -> next cycle port_req=5'b01000 (E), route_busy=1, derouted=0.
- Same config, HEADER dst=4'b0111, BODY×2 with grant, TAIL with grant -> port_req=5'b01000 held 4 cycles, then 0 and route_busy=0 the cycle after the tail grant.
- Cx=4'b1110, Dr[1:0]=2'd1, HEADER dst=4'b0001 -> port_req=5'b01000, derouted=1. Repeat with Cx=4'b1100 -> err_unroutable one pulse, port_req=0.
- FORK=1, Rxy=8'hFF, cur=4'b0101, HEADER dst=4'b0000 -> port_req=5'b10100 (N,W). FORK=0 gives 5'b10000.
- HEADER dst=cur (4'b0101), flit_id=3'b101 with grant -> port_req=5'b00001 for one cycle, then IDLE.
- IDLE with BODY flit -> err_protocol pulse. In ROUTE, cfg_load with Cx_in=0 is ignored (route held); rst asserted mid-packet -> port_req=0, IDLE.
